// File: rtl/ufm_evt_sched_if.sv
// Event-in and UFM-write bus of the event scheduler, named from the scheduler's side.
// master = scheduler, slave = event source / UFM write engine.
interface ufm_evt_sched_if;
    logic        evt_vld_i;
    logic [7:0]  evt_code_i;
    logic        wr_req_o;
    logic [11:0] wr_addr_o;
    logic [7:0]  wr_data_o;
    logic        wr_ack_i;

    modport master (
        input  evt_vld_i,
        input  evt_code_i,
        input  wr_ack_i,
        output wr_req_o,
        output wr_addr_o,
        output wr_data_o
    );

    modport slave (
        output evt_vld_i,
        output evt_code_i,
        output wr_ack_i,
        input  wr_req_o,
        input  wr_addr_o,
        input  wr_data_o
    );
endinterface

// File: rtl/ufm_evt_sched.sv
// UFM event logger: buffers event codes and writes each to the next UFM page.
// Ack timeout, retry and drop handling are built only with `define UFM_SCHED_TIMEOUT_EN.

// Generic synchronous FIFO, DEPTH a power of two (>= 2).
// Latency: a push into an empty FIFO is visible at head_dat_o after one edge.
// Backpressure: push is refused when full unless a pop happens on the same edge.
module ufm_evt_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_vld_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o     = (count_q == CNT_FULL);
    assign empty_o    = (count_q == '0);
    assign head_dat_o = mem_q[rd_ptr_q];
    assign do_pop     = pop_i && !empty_o;
    assign do_push    = push_vld_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end
endmodule

// Scheduler: one UFM page write at a time; the page pointer advances only on ack.
// Latency: wr_req_o rises on the 3rd edge after the event edge (empty FIFO, hold low).
// Backpressure: ufm_hold_i stalls new starts only; a push into a full FIFO is lost and sets ovf_o.
module ufm_evt_sched #(
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [11:0] LAST_PAGE   = 12'd255,
    parameter logic [15:0] ACK_TIMEOUT = 16'd1000,
    parameter logic [1:0]  MAX_RETRY   = 2'd3
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            ufm_hold_i,
    ufm_evt_sched_if.master bus,
    output logic            fifo_full_o,
    output logic            ovf_o,
    output logic            err_o
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_HOLD,
        S_ISSUE,
        S_WAIT_ACK,
        S_BACKOFF
    } state_t;

    state_t      state_q;
    logic        wr_req_q;
    logic [11:0] wr_addr_q;
    logic [7:0]  wr_data_q;
    logic [11:0] page_q;
    logic        ovf_q;

    logic [7:0]  head_dat;
    logic        fifo_empty;
    logic        fifo_full;
    logic        fifo_pop;
    logic        ack_hit;

    // Ack only counts while a write is outstanding; stray strobes are ignored.
    assign ack_hit = (state_q == S_WAIT_ACK) && bus.wr_ack_i;

`ifdef UFM_SCHED_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;
    logic [1:0]  retry_q;
    logic [3:0]  boff_cnt_q;
    logic        err_q;
    logic        tmo_hit;
    logic        drop_hit;

    // An ack on the timeout cycle takes priority, so tmo_hit excludes it.
    assign tmo_hit  = (state_q == S_WAIT_ACK) && !bus.wr_ack_i &&
                      (tmo_cnt_q == ACK_TIMEOUT - 16'd1);
    assign drop_hit = tmo_hit && (retry_q == MAX_RETRY);
    assign fifo_pop = ack_hit || drop_hit;
    assign err_o    = err_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^{ACK_TIMEOUT, MAX_RETRY};
    assign fifo_pop   = ack_hit;
    assign err_o      = 1'b0;
`endif

    ufm_evt_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_vld_i (bus.evt_vld_i),
        .push_dat_i (bus.evt_code_i),
        .pop_i      (fifo_pop),
        .head_dat_o (head_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign fifo_full_o   = fifo_full;
    assign ovf_o         = ovf_q;
    assign bus.wr_req_o  = wr_req_q;
    assign bus.wr_addr_o = wr_addr_q;
    assign bus.wr_data_o = wr_data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            wr_req_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            page_q     <= '0;
            ovf_q      <= 1'b0;
`ifdef UFM_SCHED_TIMEOUT_EN
            tmo_cnt_q  <= '0;
            retry_q    <= '0;
            boff_cnt_q <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            // A simultaneous pop frees the slot, so only an unmatched push into a full FIFO is lost.
            if (bus.evt_vld_i && fifo_full && !fifo_pop) begin
                ovf_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        state_q <= S_WAIT_HOLD;
                    end
                end

                S_WAIT_HOLD: begin
                    if (!ufm_hold_i) begin
                        state_q <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    wr_req_q  <= 1'b1;
                    wr_addr_q <= page_q;
                    wr_data_q <= head_dat;
`ifdef UFM_SCHED_TIMEOUT_EN
                    tmo_cnt_q <= '0;
`endif
                    state_q   <= S_WAIT_ACK;
                end

                S_WAIT_ACK: begin
                    if (ack_hit) begin
                        wr_req_q <= 1'b0;
                        page_q   <= (page_q == LAST_PAGE) ? 12'd0 : page_q + 12'd1;
`ifdef UFM_SCHED_TIMEOUT_EN
                        retry_q  <= '0;
`endif
                        state_q  <= S_IDLE;
                    end
`ifdef UFM_SCHED_TIMEOUT_EN
                    else if (tmo_hit) begin
                        wr_req_q <= 1'b0;
                        if (drop_hit) begin
                            // Give up: event already popped, page left for the next event.
                            err_q   <= 1'b1;
                            retry_q <= '0;
                            state_q <= S_IDLE;
                        end else begin
                            retry_q    <= retry_q + 2'd1;
                            boff_cnt_q <= '0;
                            state_q    <= S_BACKOFF;
                        end
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 16'd1;
                    end
`endif
                end

                S_BACKOFF: begin
`ifdef UFM_SCHED_TIMEOUT_EN
                    if (boff_cnt_q == 4'd15) begin
                        state_q <= S_WAIT_HOLD;
                    end else begin
                        boff_cnt_q <= boff_cnt_q + 4'd1;
                    end
`else
                    state_q <= S_IDLE;
`endif
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ufm_evt_sched.sv
// Directed bench for ufm_evt_sched: scoreboard of {page, code} per accepted event, checked at each write.
module tb_ufm_evt_sched;
`ifdef UFM_SCHED_TIMEOUT_EN
    localparam logic [15:0] TB_TMO = 16'd20;
`else
    localparam logic [15:0] TB_TMO = 16'd1000;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ufm_hold_i;
    logic        fifo_full_o;
    logic        ovf_o;
    logic        err_o;

    int          total = 0;
    int          bad   = 0;
    logic [19:0] exp_q [$];
    logic [11:0] mdl_page;

    ufm_evt_sched_if bus_if ();

    ufm_evt_sched #(
        .FIFO_DEPTH  (4),
        .LAST_PAGE   (12'd255),
        .ACK_TIMEOUT (TB_TMO),
        .MAX_RETRY   (2'd3)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .ufm_hold_i  (ufm_hold_i),
        .bus         (bus_if),
        .fifo_full_o (fifo_full_o),
        .ovf_o       (ovf_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    task automatic model_push(input logic [7:0] code);
        exp_q.push_back({mdl_page, code});
        mdl_page = (mdl_page == 12'd255) ? 12'd0 : mdl_page + 12'd1;
    endtask

    task automatic send_evt(input logic [7:0] code, input bit accept);
        bus_if.evt_vld_i  = 1'b1;
        bus_if.evt_code_i = code;
        if (accept) model_push(code);
        tick();
        bus_if.evt_vld_i  = 1'b0;
    endtask

    task automatic wait_req(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus_if.wr_req_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic serve(input int ack_dly, output logic [11:0] addr);
        bit          ok;
        logic [19:0] e;
        addr = 'x;
        wait_req(100, ok);
        check("req_seen", 32'(ok), 32'd1);
        if (!ok) return;
        check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() == 0) return;
        e    = exp_q.pop_front();
        addr = bus_if.wr_addr_o;
        check("wr_addr", 32'(bus_if.wr_addr_o), 32'(e[19:8]));
        check("wr_data", 32'(bus_if.wr_data_o), 32'(e[7:0]));
        repeat (ack_dly) tick();
        check("req_held", 32'(bus_if.wr_req_o), 32'd1);
        bus_if.wr_ack_i = 1'b1;
        tick();
        bus_if.wr_ack_i = 1'b0;
        check("req_drop", 32'(bus_if.wr_req_o), 32'd0);
    endtask

    initial begin
        logic [11:0] a;
        logic [19:0] e;
        bit          ok;
        int          n;

        rst_i             = 1'b1;
        ufm_hold_i        = 1'b0;
        bus_if.evt_vld_i  = 1'b0;
        bus_if.evt_code_i = 8'h00;
        bus_if.wr_ack_i   = 1'b0;
        mdl_page          = 12'd0;
        repeat (3) tick();
        check("rst_req",  32'(bus_if.wr_req_o),  32'd0);
        check("rst_addr", 32'(bus_if.wr_addr_o), 32'd0);
        check("rst_data", 32'(bus_if.wr_data_o), 32'd0);
        check("rst_full", 32'(fifo_full_o), 32'd0);
        check("rst_ovf",  32'(ovf_o), 32'd0);
        check("rst_err",  32'(err_o), 32'd0);
        rst_i = 1'b0;
        tick();

        // First event: wr_req on the 3rd edge after the push edge, then page 0 / page 1.
        send_evt(8'hA5, 1'b1);
        check("lat_e0", 32'(bus_if.wr_req_o), 32'd0);
        tick();
        check("lat_e1", 32'(bus_if.wr_req_o), 32'd0);
        tick();
        check("lat_e2", 32'(bus_if.wr_req_o), 32'd0);
        tick();
        check("lat_e3", 32'(bus_if.wr_req_o), 32'd1);
        serve(4, a);
        check("first_page", 32'(a), 32'd0);
        send_evt(8'h5A, 1'b1);
        serve(2, a);
        check("second_page", 32'(a), 32'd1);

        // Long hold with a stray ack while waiting; release starts the write two edges later.
        ufm_hold_i = 1'b1;
        send_evt(8'h11, 1'b1);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            bus_if.wr_ack_i = (i == 20);
            tick();
            if (bus_if.wr_req_o !== 1'b0) n++;
        end
        bus_if.wr_ack_i = 1'b0;
        check("hold_req_low", 32'(n), 32'd0);
        ufm_hold_i = 1'b0;
        tick();
        check("hold_rel_e1", 32'(bus_if.wr_req_o), 32'd0);
        tick();
        check("hold_rel_e2", 32'(bus_if.wr_req_o), 32'd1);
        serve(1, a);

        // Hold rising mid-write must not abort it.
        send_evt(8'h22, 1'b1);
        wait_req(20, ok);
        check("midw_req_up", 32'(ok), 32'd1);
        ufm_hold_i = 1'b1;
        n = 0;
        repeat (10) begin
            tick();
            if (bus_if.wr_req_o !== 1'b1) n++;
        end
        check("hold_no_abort", 32'(n), 32'd0);
        serve(0, a);
        ufm_hold_i = 1'b0;

        // Five events against a depth-4 FIFO under hold.
        ufm_hold_i = 1'b1;
        for (int i = 0; i < 4; i++) send_evt(8'(8'h40 + i), 1'b1);
        check("fill_full", 32'(fifo_full_o), 32'd1);
        check("fill_ovf0", 32'(ovf_o), 32'd0);
        send_evt(8'h4F, 1'b0);
        check("ovf_set", 32'(ovf_o), 32'd1);
        check("ovf_full", 32'(fifo_full_o), 32'd1);
        check("ovf_no_req", 32'(bus_if.wr_req_o), 32'd0);
        ufm_hold_i = 1'b0;
        serve(0, a);
        check("full_clr", 32'(fifo_full_o), 32'd0);
        repeat (3) serve(0, a);
        check("fill_drained", 32'(exp_q.size()), 32'd0);
        check("ovf_sticky", 32'(ovf_o), 32'd1);

        // Reset during WAIT_ACK.
        send_evt(8'h33, 1'b1);
        wait_req(20, ok);
        check("rstw_req_up", 32'(ok), 32'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("rstw_req",  32'(bus_if.wr_req_o),  32'd0);
        check("rstw_addr", 32'(bus_if.wr_addr_o), 32'd0);
        check("rstw_data", 32'(bus_if.wr_data_o), 32'd0);
        check("rstw_full", 32'(fifo_full_o), 32'd0);
        check("rstw_ovf",  32'(ovf_o), 32'd0);
        check("rstw_err",  32'(err_o), 32'd0);
        exp_q.delete();
        mdl_page = 12'd0;
        send_evt(8'h44, 1'b1);
        serve(0, a);
        check("rstw_page0", 32'(a), 32'd0);

        // Push and pop on the same edge while full: no overflow.
        ufm_hold_i = 1'b1;
        for (int i = 0; i < 4; i++) send_evt(8'(8'h60 + i), 1'b1);
        check("pp_full_pre", 32'(fifo_full_o), 32'd1);
        ufm_hold_i = 1'b0;
        wait_req(20, ok);
        check("pp_req_up", 32'(ok), 32'd1);
        e = exp_q.pop_front();
        check("pp_addr", 32'(bus_if.wr_addr_o), 32'(e[19:8]));
        check("pp_data", 32'(bus_if.wr_data_o), 32'(e[7:0]));
        bus_if.wr_ack_i   = 1'b1;
        bus_if.evt_vld_i  = 1'b1;
        bus_if.evt_code_i = 8'h99;
        model_push(8'h99);
        tick();
        bus_if.wr_ack_i  = 1'b0;
        bus_if.evt_vld_i = 1'b0;
        check("pp_ovf",  32'(ovf_o), 32'd0);
        check("pp_full", 32'(fifo_full_o), 32'd1);
        repeat (4) serve(0, a);

        // Walk the pointer up to LAST_PAGE, then check the wrap to 0.
        for (int i = 0; i < 300 && mdl_page != 12'd255; i++) begin
            send_evt(8'(i), 1'b1);
            serve(0, a);
        end
        send_evt(8'hE1, 1'b1);
        serve(1, a);
        check("wrap_hi", 32'(a), 32'd255);
        send_evt(8'hE2, 1'b1);
        serve(1, a);
        check("wrap_lo", 32'(a), 32'd0);

`ifdef UFM_SCHED_TIMEOUT_EN
        // Never ack: 4 pulses of ACK_TIMEOUT, gaps of 16 backoff + WAIT_HOLD + ISSUE, then drop.
        send_evt(8'hDD, 1'b0);
        wait_req(20, ok);
        check("tmo_req_up", 32'(ok), 32'd1);
        for (int p = 0; p < 4; p++) begin
            n = 0;
            while (bus_if.wr_req_o === 1'b1 && n < 100) begin
                n++;
                tick();
            end
            check("tmo_pulse", 32'(n), 32'(TB_TMO));
            if (p < 3) begin
                n = 0;
                while (bus_if.wr_req_o !== 1'b1 && n < 100) begin
                    n++;
                    tick();
                end
                check("tmo_gap", 32'(n), 32'd18);
            end
        end
        check("tmo_err", 32'(err_o), 32'd1);
        send_evt(8'hDE, 1'b1);
        serve(0, a);
        check("tmo_page_kept", 32'(a), 32'd1);
`else
        // Without the timeout build the request waits for an ack indefinitely.
        send_evt(8'hDD, 1'b1);
        wait_req(20, ok);
        check("notmo_req_up", 32'(ok), 32'd1);
        n = 0;
        repeat (1100) begin
            tick();
            if (bus_if.wr_req_o !== 1'b1) n++;
        end
        check("notmo_held", 32'(n), 32'd0);
        check("notmo_err", 32'(err_o), 32'd0);
        serve(0, a);
`endif

        check("sb_final", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
